// File: rtl/spike_encoder.sv
// Rate encoder: a phase accumulator turns an input level into a spike train,
// an optional refractory period follows each spike, and a windowed counter
// publishes the spike total of each completed window.
module spike_encoder #(
  parameter int WIDTH   = 8,
  parameter int REFRACT = 0,
  parameter int WINDOW  = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] I_stim,
  output logic             spike,
  output logic [7:0]       spike_count,
  output logic             window_done
);

  localparam int WC_W = $clog2(WINDOW);
  localparam int RC_W = (REFRACT > 1) ? $clog2(REFRACT) : 1;
  localparam logic [WC_W-1:0] WIN_LAST = WC_W'(WINDOW - 1);
  localparam logic [RC_W-1:0] RC_LOAD  = RC_W'((REFRACT > 0) ? REFRACT - 1 : 0);

  typedef enum logic {
    ST_INTEGRATE = 1'b0,
    ST_REFRACT   = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [RC_W-1:0]   ref_cnt_q, ref_cnt_d;
  logic [WC_W-1:0]   win_cnt_q, win_cnt_d;
  logic [7:0]        spk_cnt_q, spk_cnt_d;
  logic              spike_q, spike_d;
  logic [7:0]        spike_count_q, spike_count_d;
  logic              window_done_q, window_done_d;
  logic [WIDTH:0]    sum;

  // Add one (possibly zero) spike to an 8-bit count, pinning at 255.
  function automatic logic [7:0] sat255(input logic [7:0] a, input logic b);
    logic [8:0] t;
    t = {1'b0, a} + {8'd0, b};
    return t[8] ? 8'hFF : t[7:0];
  endfunction

  // Next-state logic: accumulator/refractory FSM and window bookkeeping.
  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    ref_cnt_d     = ref_cnt_q;
    win_cnt_d     = win_cnt_q;
    spk_cnt_d     = spk_cnt_q;
    spike_count_d = spike_count_q;
    spike_d       = 1'b0;
    window_done_d = 1'b0;
    sum           = {1'b0, acc_q} + {1'b0, I_stim};

    if (!en) begin
      // Disabling abandons any refractory period but keeps acc and window.
      state_d   = ST_INTEGRATE;
      ref_cnt_d = '0;
    end else begin
      case (state_q)
        ST_INTEGRATE: begin
          acc_d = sum[WIDTH-1:0];
          if (sum[WIDTH]) begin
            spike_d = 1'b1;
            if (REFRACT > 0) begin
              state_d   = ST_REFRACT;
              ref_cnt_d = RC_LOAD;
            end
          end
        end
        ST_REFRACT: begin
          if (ref_cnt_q == '0) state_d = ST_INTEGRATE;
          else                 ref_cnt_d = ref_cnt_q - RC_W'(1);
        end
        default: state_d = ST_INTEGRATE;
      endcase

      // The spike currently on the output belongs to this window, even on
      // its last cycle; a carry made now shows up in the next window.
      if (win_cnt_q == WIN_LAST) begin
        spike_count_d = sat255(spk_cnt_q, spike_q);
        window_done_d = 1'b1;
        spk_cnt_d     = '0;
        win_cnt_d     = '0;
      end else begin
        spk_cnt_d = sat255(spk_cnt_q, spike_q);
        win_cnt_d = win_cnt_q + WC_W'(1);
      end
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_INTEGRATE;
      acc_q         <= '0;
      ref_cnt_q     <= '0;
      win_cnt_q     <= '0;
      spk_cnt_q     <= '0;
      spike_q       <= 1'b0;
      spike_count_q <= '0;
      window_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      ref_cnt_q     <= ref_cnt_d;
      win_cnt_q     <= win_cnt_d;
      spk_cnt_q     <= spk_cnt_d;
      spike_q       <= spike_d;
      spike_count_q <= spike_count_d;
      window_done_q <= window_done_d;
    end
  end

  assign spike       = spike_q;
  assign spike_count = spike_count_q;
  assign window_done = window_done_q;

endmodule

// File: tb/tb_spike_encoder.sv
// Scoreboard bench for spike_encoder: three configurations (default,
// REFRACT=2, WINDOW=300) share one stimulus stream; a behavioural model
// predicts per-cycle outputs and published window counts.
module tb_spike_encoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [7:0] I_stim;

  logic       spike_o [3];
  logic [7:0] cnt_o   [3];
  logic       wd_o    [3];

  always #5 clk = ~clk;

  spike_encoder #(.WIDTH(8), .REFRACT(0), .WINDOW(256)) u_def (
    .clk(clk), .rst_n(rst_n), .en(en), .I_stim(I_stim),
    .spike(spike_o[0]), .spike_count(cnt_o[0]), .window_done(wd_o[0]));

  spike_encoder #(.WIDTH(8), .REFRACT(2), .WINDOW(256)) u_ref (
    .clk(clk), .rst_n(rst_n), .en(en), .I_stim(I_stim),
    .spike(spike_o[1]), .spike_count(cnt_o[1]), .window_done(wd_o[1]));

  spike_encoder #(.WIDTH(8), .REFRACT(0), .WINDOW(300)) u_win (
    .clk(clk), .rst_n(rst_n), .en(en), .I_stim(I_stim),
    .spike(spike_o[2]), .spike_count(cnt_o[2]), .window_done(wd_o[2]));

  typedef struct packed {
    logic       spk;
    logic       wd;
    logic [7:0] cnt;
  } exp_t;

  exp_t cyc_q [3][$];
  int   win_q [3][$];

  int n_tests  = 0;
  int n_fail   = 0;
  int sat_seen = 0;

  // Model state: accumulator value, refractory cycles still to skip,
  // position in window, raw spikes in window, last published count.
  int m_acc [3];
  int m_blk [3];
  int m_pos [3];
  int m_cnt [3];
  int m_pub [3];
  bit m_spk [3];

  function automatic int rf(input int k);
    return (k == 1) ? 2 : 0;
  endfunction

  function automatic int wn(input int k);
    return (k == 2) ? 300 : 256;
  endfunction

  // Predict what each DUT shows after the coming clock edge.
  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      exp_t e;
      bit   wd;
      int   s;
      int   tot;
      wd = 1'b0;
      if (!rst_n) begin
        m_acc[k] = 0; m_blk[k] = 0; m_pos[k] = 0;
        m_cnt[k] = 0; m_pub[k] = 0; m_spk[k] = 1'b0;
      end else if (en) begin
        if (m_pos[k] == wn(k) - 1) begin
          tot      = m_cnt[k] + int'(m_spk[k]);
          m_pub[k] = (tot > 255) ? 255 : tot;
          win_q[k].push_back(m_pub[k]);
          wd       = 1'b1;
          m_cnt[k] = 0;
          m_pos[k] = 0;
        end else begin
          m_cnt[k] = m_cnt[k] + int'(m_spk[k]);
          m_pos[k] = m_pos[k] + 1;
        end
        if (m_blk[k] > 0) begin
          m_blk[k] = m_blk[k] - 1;
          m_spk[k] = 1'b0;
        end else begin
          s        = m_acc[k] + int'(I_stim);
          m_spk[k] = (s >= 256);
          m_acc[k] = s % 256;
          if (m_spk[k]) m_blk[k] = rf(k);
        end
      end else begin
        m_spk[k] = 1'b0;
        m_blk[k] = 0;
      end
      e.spk = m_spk[k];
      e.wd  = wd;
      e.cnt = 8'(m_pub[k]);
      cyc_q[k].push_back(e);
    end
  endtask

  task automatic drive(input bit r, input bit e, input int s, input int n);
    repeat (n) begin
      @(negedge clk);
      rst_n  = r;
      en     = e;
      I_stim = s[7:0];
      model_step();
    end
  endtask

  // Monitor: compare every cycle's outputs, and each window_done's count.
  initial begin
    exp_t ex;
    int   w;
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
        if (cyc_q[k].size() > 0) begin
          ex = cyc_q[k].pop_front();
          n_tests++;
          if (spike_o[k] !== ex.spk || wd_o[k] !== ex.wd || cnt_o[k] !== ex.cnt) begin
            n_fail++;
            $display("FAIL outputs[%0d] t=%0t got spike=%0b wd=%0b cnt=%0d, expected spike=%0b wd=%0b cnt=%0d",
                     k, $time, spike_o[k], wd_o[k], cnt_o[k], ex.spk, ex.wd, ex.cnt);
          end
        end
        if (wd_o[k] === 1'b1) begin
          n_tests++;
          if (win_q[k].size() == 0) begin
            n_fail++;
            $display("FAIL window[%0d] t=%0t unexpected window_done, cnt=%0d", k, $time, cnt_o[k]);
          end else begin
            w = win_q[k].pop_front();
            if (int'(cnt_o[k]) != w) begin
              n_fail++;
              $display("FAIL window[%0d] t=%0t got count %0d, expected %0d", k, $time, cnt_o[k], w);
            end else if (k == 2 && cnt_o[k] == 8'd255) begin
              sat_seen++;
            end
          end
        end
      end
    end
  end

  // Stimulus: directed scenarios followed by randomized traffic.
  initial begin
    int s;
    bit r;
    bit e;
    rst_n  = 1'b0;
    en     = 1'b0;
    I_stim = 8'd0;
    drive(0, 0, 0, 2);

    // Zero stimulus: no spikes, windows at 256 and 512 with count 0.
    drive(1, 1, 0, 600);

    // Half-scale: spike every other cycle, counts 127 then 128.
    drive(0, 0, 0, 1);
    drive(1, 1, 128, 600);

    // Full-scale: refractory 1-in-3, and saturation in the 300-cycle window.
    drive(0, 0, 0, 1);
    drive(1, 1, 255, 700);

    // Drop enable while the REFRACT=2 instance is mid-refractory.
    for (int i = 0; i < 10; i++) begin
      if (m_blk[1] > 0) break;
      drive(1, 1, 255, 1);
    end
    drive(1, 0, 255, 50);
    drive(1, 1, 255, 400);

    // One-cycle reset while the default instance shows a spike.
    drive(1, 1, 128, 3);
    for (int i = 0; i < 10; i++) begin
      if (m_spk[0]) break;
      drive(1, 1, 128, 1);
    end
    drive(0, 1, 128, 1);
    drive(1, 1, 128, 300);

    // Randomized levels, enable gaps and occasional resets.
    s = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 40 == 0) begin
        case ($urandom_range(0, 3))
          0: s = 0;
          1: s = 255;
          2: s = 128;
          default: s = int'($urandom_range(0, 255));
        endcase
      end
      r = ($urandom_range(0, 499) != 0);
      e = ($urandom_range(0, 9) != 0);
      drive(r, e, s, 1);
    end

    @(posedge clk);
    @(posedge clk);
    #2;
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (cyc_q[k].size() != 0 || win_q[k].size() != 0) begin
        n_fail++;
        $display("FAIL drain[%0d] got %0d cycle / %0d window entries left, expected 0",
                 k, cyc_q[k].size(), win_q[k].size());
      end
    end
    n_tests++;
    if (sat_seen == 0) begin
      n_fail++;
      $display("FAIL saturation got %0d windows reporting 255, expected at least 1", sat_seen);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spike_encoder.md
# spike_encoder

Rate encoder that converts an 8-bit stimulus level into a spike train whose average rate is proportional to the level. It is the counterpart of the team's neuron decoder, which integrates `I_syn` into `V_mem`. The encoder drives spike trains into that path, and its per-window spike count gives a measurable rate readback for bring-up. It has a phase accumulator, a refractory counter and a windowed spike counter.

## Interface
Parameters:
- `WIDTH`, default 8: stimulus and accumulator width.
- `REFRACT`, default 0: refractory cycles after each carry. 0 disables the refractory period.
- `WINDOW`, default 256: number of enabled cycles per rate-count window. Must be ≥ 2.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `en`  in  1  encoder enable. Low holds the accumulator and freezes the window.
- `I_stim`  in  WIDTH  stimulus level, sampled every integrating cycle.
- `spike`  out  1  registered spike pulse, one cycle high per carry.
- `spike_count`  out  8  spike total of the last completed window, saturating at 255.
- `window_done`  out  1  one-cycle pulse when `spike_count` updates.

## Operation
- **State machine:** two states, INTEGRATE and REFRACT. `en` gates both states.
- **INTEGRATE, `en`=1:**
  - Form `sum = acc + I_stim` at WIDTH+1 bits.
  - No carry (`sum[WIDTH]`=0): `acc <= sum[WIDTH-1:0]`, `spike <= 0`.
  - Carry: `acc <= sum[WIDTH-1:0]`, `spike <= 1`.
  - On carry with `REFRACT` > 0: go to REFRACT with `ref_cnt <= REFRACT-1`. With `REFRACT` = 0, stay in INTEGRATE.
- **REFRACT, `en`=1:**
  - `acc` holds and `spike <= 0`.
  - If `ref_cnt` = 0, go to INTEGRATE; otherwise decrement `ref_cnt`.
- **`en`=0, any state:**
  - `spike <= 0`; `acc` retained.
  - State forced to INTEGRATE and `ref_cnt <= 0`, so any pending refractory period is abandoned.
  - Window counters hold.
- **Window counting:**
  - `win_cnt` counts `en`=1 cycles from 0 to WINDOW-1.
  - `spk_cnt` increments, saturating at 255, on each `en`=1 cycle in which the registered `spike` is 1.
  - On the `en`=1 cycle with `win_cnt` = WINDOW-1:
    - `spike_count <= sat255(spk_cnt + spike)`, `window_done <= 1`.
    - `spk_cnt <= 0`, `win_cnt <= 0`.
  - All other cycles: `window_done <= 0`.
- **`I_stim` = 0:** never produces a carry. **`I_stim` = 2^WIDTH-1:** with `REFRACT` = 0, produces 2^WIDTH-1 carries per 2^WIDTH integrating cycles.
- **Stimulus changes** take effect on the next integrating cycle. No other state is disturbed.

## Timing
- **Reset** (`rst_n`=0 at an edge): `acc`=0, state INTEGRATE, `ref_cnt`=0, `win_cnt`=0, `spk_cnt`=0, `spike`=0, `spike_count`=0, `window_done`=0.
- **Reset mid-window or mid-refractory:** discards everything. No partial count is published.
- **Spike latency:** `spike` is high in the cycle after the integrating cycle that carried.
- **Back-to-back carries** (`REFRACT`=0, `I_stim` ≥ 2^(WIDTH-1)) give consecutive or alternate high cycles. Each high cycle counts as one spike.
- **Spike period** for constant `I_stim`=S with carries: average 2^WIDTH/S integrating cycles, plus `REFRACT` cycles per spike.
- **Window boundary:**
  - A spike visible on the final window cycle is counted in that window.
  - A carry made on the final window cycle appears as a spike, and is counted, in the next window.
- **`window_done`** is high the cycle after the final window cycle, aligned with the new `spike_count`. Its period is WINDOW enabled cycles.

## Test plan
- Reset, then `en`=1 with `I_stim`=0 for 600 cycles:
  - `spike` stays 0.
  - `window_done` pulses at cycles 256 and 512 after `en` rose.
  - `spike_count` = 0.
- `REFRACT`=0, `I_stim`=128 from reset:
  - First spike 2 cycles after `en` rose, then every 2 cycles.
  - `spike_count` is 127 after the first window and 128 after the second.
- `REFRACT`=2, `I_stim`=255:
  - `spike` is high 1 cycle in every 3.
  - Each spike is followed by exactly 2 low cycles with `acc` unchanged.
- `I_stim`=255, `REFRACT`=0, `WINDOW`=300:
  - A window that would hold more than 255 spikes reports `spike_count` = 255 (saturation).
- Drop `en` for 50 cycles mid-window, mid-refractory:
  - `acc` and `win_cnt` hold.
  - After re-enable, integration resumes immediately with no refractory remainder.
  - `window_done` is delayed by exactly 50 cycles.
- Assert `rst_n`=0 for 1 cycle mid-window while `spike` is high:
  - Next cycle all outputs are 0.
  - The window restarts, with the next `window_done` 256 enabled cycles later.
